pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV64 core.
- Drives stall, flush and bubble controls into the IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Resolves load-use hazards, multi-cycle MUL/DIV waits, memory wait-states and branch/jump redirects.
- Sole owner of pipeline-register sequencing; no other block drives these control inputs.

---
 rtl/pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central pipeline sequencer for the 5-stage RV64 core.
// Owns the stall/flush/bubble controls of the IF/ID, ID/EXE and EXE/MEM
// pipeline registers. Resolves load-use hazards, MUL/DIV waits (with a
// watchdog), data-memory wait-states and branch/jump redirects.
//
// Parameters:
//   FLUSH_CYCLES  cycles of IF/ID flush after a redirect (1..7)
//   MDU_TIMEOUT   max MDU_WAIT cycles before the MUL/DIV op is abandoned (2..255)
//
// Ports:
//   clk, rst (synchronous, active-low)
//   id_*          ID-stage instruction and its source-register usage
//   exe_*         EXE-stage instruction: dest reg, load/MDU/redirect flags
//   mdu_done      MUL/DIV result ready (1-cycle pulse)
//   mem_req/ready MEM-stage data access handshake
//   if_stall/id_stall/exe_stall      hold IF/ID, ID/EXE, EXE/MEM
//   id_flush/exe_bubble/mem_bubble   zero IF/ID, ID/EXE, EXE/MEM
//   mdu_start     start pulse to MUL/DIV unit
//   mdu_timeout   sticky watchdog error flag
//   ctrl_state    RUN=0, MEM_WAIT=1, MDU_WAIT=2, FLUSH=3
//
// Optional build macro PIPE_HAZARD_PERF_CNT_EN adds perf_stall_cnt and
// perf_flush_cnt (64-bit, wrapping) outputs.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MDU_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       exe_valid,
  input  logic [4:0] exe_rd,
  input  logic       exe_is_load,
  input  logic       exe_is_mdu,
  input  logic       exe_redirect,
  input  logic       mdu_done,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       if_stall,
  output logic       id_stall,
  output logic       exe_stall,
  output logic       id_flush,
  output logic       exe_bubble,
  output logic       mem_bubble,
  output logic       mdu_start,
  output logic       mdu_timeout,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LAST    = 8'(MDU_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;

  logic mem_stall, redirect, load_use, accept_redirect;
  logic c_if_stall, c_id_stall, c_exe_stall;
  logic c_id_flush, c_exe_bubble, c_mem_bubble, c_mdu_start;

  assign mem_stall = mem_req & ~mem_ready;
  assign redirect  = exe_redirect & exe_valid;
  assign load_use  = exe_valid & exe_is_load & (exe_rd != 5'd0) & id_valid &
                     ((id_rs1_used & (id_rs1 == exe_rd)) |
                      (id_rs2_used & (id_rs2 == exe_rd)));

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    wd_d            = wd_q;
    timeout_d       = timeout_q;
    accept_redirect = 1'b0;
    c_if_stall      = 1'b0;
    c_id_stall      = 1'b0;
    c_exe_stall     = 1'b0;
    c_id_flush      = 1'b0;
    c_exe_bubble    = 1'b0;
    c_mem_bubble    = 1'b0;
    c_mdu_start     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          c_if_stall  = 1'b1;
          c_id_stall  = 1'b1;
          c_exe_stall = 1'b1;
          state_d     = MEM_WAIT;
        end else if (redirect) begin
          c_id_flush      = 1'b1;
          c_exe_bubble    = 1'b1;
          accept_redirect = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end else if (exe_valid & exe_is_mdu) begin
          c_mdu_start  = 1'b1;
          c_if_stall   = 1'b1;
          c_id_stall   = 1'b1;
          c_mem_bubble = 1'b1;
          wd_d         = '0;
          state_d      = MDU_WAIT;
        end else if (load_use) begin
          c_if_stall   = 1'b1;
          c_id_stall   = 1'b1;
          c_exe_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          c_if_stall  = 1'b1;
          c_id_stall  = 1'b1;
          c_exe_stall = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MDU_WAIT: begin
        // done wins over a coinciding watchdog expiry
        if (mdu_done) begin
          state_d = RUN;
        end else begin
          c_if_stall   = 1'b1;
          c_id_stall   = 1'b1;
          c_mem_bubble = 1'b1;
          wd_d         = wd_q + 8'd1;
          if (wd_q == WD_LAST) begin
            c_exe_bubble = 1'b1;
            timeout_d    = 1'b1;
            state_d      = RUN;
          end
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          c_if_stall  = 1'b1;
          c_id_stall  = 1'b1;
          c_exe_stall = 1'b1;
          fcnt_d      = '0;
          state_d     = MEM_WAIT;
        end else if (redirect) begin
          c_id_flush      = 1'b1;
          c_exe_bubble    = 1'b1;
          accept_redirect = 1'b1;
          fcnt_d          = FLUSH_LOAD;
        end else begin
          c_id_flush = 1'b1;
          fcnt_d     = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = '0;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // All controls are forced low while reset is asserted.
  assign if_stall    = rst & c_if_stall;
  assign id_stall    = rst & c_id_stall;
  assign exe_stall   = rst & c_exe_stall;
  assign id_flush    = rst & c_id_flush;
  assign exe_bubble  = rst & c_exe_bubble;
  assign mem_bubble  = rst & c_mem_bubble;
  assign mdu_start   = rst & c_mdu_start;
  assign mdu_timeout = rst & timeout_q;
  assign ctrl_state  = state_q & {2{rst}};

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [63:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (c_if_stall)      stall_cnt_q <= stall_cnt_q + 64'd1;
      if (accept_redirect) flush_cnt_q <= flush_cnt_q + 64'd1;
    end
  end

  assign perf_stall_cnt = rst ? stall_cnt_q : '0;
  assign perf_flush_cnt = rst ? flush_cnt_q : '0;
`else
  logic unused_accept;
  assign unused_accept = accept_redirect;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (FLUSH_CYCLES=3, MDU_TIMEOUT=8): directed
// scenarios with literal expectations, then randomized traffic, with every
// cycle compared against a count-based behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int FC = 3;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic exe_valid, exe_is_load, exe_is_mdu, exe_redirect;
  logic mdu_done, mem_req, mem_ready;
  logic if_stall, id_stall, exe_stall, id_flush, exe_bubble, mem_bubble;
  logic mdu_start, mdu_timeout;
  logic [1:0] ctrl_state;

  int errors = 0;
  int checks = 0;

  // Model: mode number as reported on ctrl_state, remaining flush cycles,
  // completed MDU wait cycles, sticky error.
  int m_mode = 0, m_left = 0, m_el = 0;
  bit m_err = 1'b0;
  int n_mode, n_left, n_el;
  bit n_err;
  logic [9:0] exp_v;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_is_mdu(exe_is_mdu), .exe_redirect(exe_redirect),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_stall(if_stall), .id_stall(id_stall), .exe_stall(exe_stall),
    .id_flush(id_flush), .exe_bubble(exe_bubble), .mem_bubble(mem_bubble),
    .mdu_start(mdu_start), .mdu_timeout(mdu_timeout), .ctrl_state(ctrl_state)
  );

  function automatic logic [9:0] pack(input bit ifs, input bit ids, input bit exs,
                                      input bit idf, input bit exb, input bit meb,
                                      input bit ms, input bit to, input int st);
    return {ifs, ids, exs, idf, exb, meb, ms, to, st[1:0]};
  endfunction

  function automatic logic [9:0] actual();
    return {if_stall, id_stall, exe_stall, id_flush, exe_bubble, mem_bubble,
            mdu_start, mdu_timeout, ctrl_state};
  endfunction

  task automatic model_eval();
    bit ifs, ids, exs, idf, exb, meb, ms, hz, mstall, redir;
    ifs = 0; ids = 0; exs = 0; idf = 0; exb = 0; meb = 0; ms = 0;
    n_mode = m_mode; n_left = m_left; n_el = m_el; n_err = m_err;
    if (!rst) begin
      exp_v = '0;
      n_mode = 0; n_left = 0; n_el = 0; n_err = 0;
      return;
    end
    mstall = mem_req && !mem_ready;
    redir  = exe_redirect && exe_valid;
    hz = exe_valid && exe_is_load && exe_rd != 0 && id_valid &&
         ((id_rs1_used && id_rs1 == exe_rd) || (id_rs2_used && id_rs2 == exe_rd));
    case (m_mode)
      0: begin
        if (mstall) begin
          ifs = 1; ids = 1; exs = 1; n_mode = 1;
        end else if (redir) begin
          idf = 1; exb = 1;
          if (FC > 1) begin n_mode = 3; n_left = FC - 1; end
        end else if (exe_valid && exe_is_mdu) begin
          ms = 1; ifs = 1; ids = 1; meb = 1; n_mode = 2; n_el = 0;
        end else if (hz) begin
          ifs = 1; ids = 1; exb = 1;
        end
      end
      1: begin
        if (!mem_ready) begin ifs = 1; ids = 1; exs = 1; end
        else n_mode = 0;
      end
      2: begin
        if (mdu_done) n_mode = 0;
        else begin
          ifs = 1; ids = 1; meb = 1;
          n_el = m_el + 1;
          if (n_el == MT) begin exb = 1; n_err = 1; n_mode = 0; end
        end
      end
      default: begin
        if (mstall) begin
          ifs = 1; ids = 1; exs = 1; n_mode = 1; n_left = 0;
        end else if (redir) begin
          idf = 1; exb = 1; n_left = FC - 1;
        end else begin
          idf = 1; n_left = m_left - 1;
          if (n_left <= 0) begin n_left = 0; n_mode = 0; end
        end
      end
    endcase
    exp_v = pack(ifs, ids, exs, idf, exb, meb, ms, m_err, m_mode);
  endtask

  task automatic lit(input string name, input logic [9:0] want);
    logic [9:0] act;
    act = actual();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b (ifs ids exs idf exb meb ms to st)",
               name, $time, act, want);
    end
  endtask

  task automatic step();
    logic [9:0] act;
    #1;
    model_eval();
    act = actual();
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b want=%b (ifs ids exs idf exb meb ms to st)",
               $time, act, exp_v);
    end
    @(posedge clk);
    m_mode = n_mode; m_left = n_left; m_el = n_el; m_err = n_err;
    #1;
  endtask

  task automatic step_lit(input string name, input logic [9:0] want);
    #1;
    lit(name, want);
    #0;
    // step() adds its own settle delay; undo nothing, the extra 1 time unit
    // still lands well before the falling edge.
    step();
  endtask

  task automatic idle();
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    exe_valid = 0; exe_rd = 0; exe_is_load = 0; exe_is_mdu = 0; exe_redirect = 0;
    mdu_done = 0; mem_req = 0; mem_ready = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    #2;
    step_lit("reset_out", '0);
    step_lit("reset_hold", '0);
    rst = 1;
    step_lit("run_idle", '0);

    // load-use on rs1
    exe_valid = 1; exe_is_load = 1; exe_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    step_lit("load_use_rs1", pack(1, 1, 0, 0, 1, 0, 0, 0, 0));
    exe_valid = 0;
    step_lit("load_use_after", '0);
    exe_valid = 1; exe_rd = 0; id_rs1 = 0;
    step_lit("load_x0", '0);
    exe_rd = 7; id_rs1 = 7; id_rs1_used = 0; id_rs2 = 7; id_rs2_used = 1;
    step_lit("load_use_rs2", pack(1, 1, 0, 0, 1, 0, 0, 0, 0));
    id_rs2_used = 0;
    step_lit("load_unused_src", '0);

    // MUL completing on the third wait cycle
    idle(); exe_valid = 1; exe_is_mdu = 1;
    step_lit("mdu_start", pack(1, 1, 0, 0, 0, 1, 1, 0, 0));
    step_lit("mdu_wait1", pack(1, 1, 0, 0, 0, 1, 0, 0, 2));
    step_lit("mdu_wait2", pack(1, 1, 0, 0, 0, 1, 0, 0, 2));
    mdu_done = 1;
    step_lit("mdu_done", pack(0, 0, 0, 0, 0, 0, 0, 0, 2));
    idle();
    step_lit("mdu_after", '0);

    // DIV never completing
    exe_valid = 1; exe_is_mdu = 1;
    step_lit("div_start", pack(1, 1, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < MT - 1; i++) step_lit("div_wait", pack(1, 1, 0, 0, 0, 1, 0, 0, 2));
    step_lit("div_timeout", pack(1, 1, 0, 0, 1, 1, 0, 0, 2));
    idle();
    step_lit("timeout_flag", pack(0, 0, 0, 0, 0, 0, 0, 1, 0));
    mdu_done = 1;
    step_lit("flag_sticky", pack(0, 0, 0, 0, 0, 0, 0, 1, 0));
    mdu_done = 0; rst = 0;
    step_lit("flag_reset", '0);
    rst = 1;
    step_lit("flag_cleared", '0);

    // redirect with a 3-cycle flush
    exe_valid = 1; exe_redirect = 1;
    step_lit("redirect", pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
    idle();
    step_lit("flush1", pack(0, 0, 0, 1, 0, 0, 0, 0, 3));
    step_lit("flush2", pack(0, 0, 0, 1, 0, 0, 0, 0, 3));
    step_lit("flush_end", '0);

    // redirect blocked by a memory wait-state
    exe_valid = 1; exe_redirect = 1; mem_req = 1; mem_ready = 0;
    step_lit("redir_memstall", pack(1, 1, 1, 0, 0, 0, 0, 0, 0));
    step_lit("memwait1", pack(1, 1, 1, 0, 0, 0, 0, 0, 1));
    mem_ready = 1;
    step_lit("memwait_ready", pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
    mem_req = 0;
    step_lit("redir_after_mem", pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
    idle();
    step(); step(); step();

    // 4 cycles of memory wait with a pending load-use
    exe_valid = 1; exe_is_load = 1; exe_rd = 3; id_valid = 1; id_rs2 = 3; id_rs2_used = 1;
    mem_req = 1; mem_ready = 0;
    step_lit("lu_mem1", pack(1, 1, 1, 0, 0, 0, 0, 0, 0));
    step_lit("lu_mem2", pack(1, 1, 1, 0, 0, 0, 0, 0, 1));
    step_lit("lu_mem3", pack(1, 1, 1, 0, 0, 0, 0, 0, 1));
    step_lit("lu_mem4", pack(1, 1, 1, 0, 0, 0, 0, 0, 1));
    mem_ready = 1;
    step_lit("lu_mem_ready", pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
    mem_req = 0;
    step_lit("lu_bubble", pack(1, 1, 0, 0, 1, 0, 0, 0, 0));

    // reset in the middle of an MDU wait
    idle(); exe_valid = 1; exe_is_mdu = 1;
    step(); step(); step();
    rst = 0;
    step_lit("rst_mid_mdu", '0);
    idle();
    step_lit("rst_mid_mdu_after", '0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 99) != 0);
      id_valid     = ($urandom_range(0, 99) < 80);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rs1_used  = ($urandom_range(0, 1) == 1);
      id_rs2_used  = ($urandom_range(0, 1) == 1);
      exe_valid    = ($urandom_range(0, 99) < 75);
      exe_rd       = 5'($urandom_range(0, 3));
      exe_is_load  = ($urandom_range(0, 99) < 30);
      exe_is_mdu   = ($urandom_range(0, 99) < 15);
      exe_redirect = ($urandom_range(0, 99) < 10);
      mdu_done     = ($urandom_range(0, 99) < 20);
      mem_req      = ($urandom_range(0, 99) < 30);
      mem_ready    = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
